// File: rtl/sop_pkg.sv
// Shared literal encoding, FSM states and the per-variable literal test
// used by the sum-of-products stream evaluator.
package sop_pkg;

  localparam logic [1:0] LIT_DC   = 2'b00;
  localparam logic [1:0] LIT_NEG  = 2'b01;
  localparam logic [1:0] LIT_POS  = 2'b10;
  localparam logic [1:0] LIT_NONE = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // A literal pair is satisfied when it does not exclude the variable's value.
  function automatic logic sop_lit_ok(input logic [1:0] lit, input logic v);
    logic ok;
    case (lit)
      LIT_DC:   ok = 1'b1;
      LIT_NEG:  ok = ~v;
      LIT_POS:  ok = v;
      LIT_NONE: ok = 1'b0;
      default:  ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/sop_stream_eval_if.sv
// Handshake bundle for sop_stream_eval: input vector load, product-term
// stream and result drain, plus status.
interface sop_stream_eval_if #(
  parameter int WIDTH        = 8,
  parameter int MAX_PRODUCTS = 8
);
  localparam int CW = $clog2(MAX_PRODUCTS + 1);

  logic                   a_valid;
  logic                   a_ready;
  logic [WIDTH-1:0]       a_data;
  logic                   chain;
  logic                   t_valid;
  logic                   t_ready;
  logic [2*(WIDTH+1)-1:0] t_data;
  logic                   t_last;
  logic                   y_valid;
  logic                   y_ready;
  logic                   y;
  logic [CW-1:0]          term_cnt;
  logic                   overflow;

  modport master (
    output a_valid, a_data, chain, t_valid, t_data, t_last, y_ready,
    input  a_ready, t_ready, y_valid, y, term_cnt, overflow
  );

  modport slave (
    input  a_valid, a_data, chain, t_valid, t_data, t_last, y_ready,
    output a_ready, t_ready, y_valid, y, term_cnt, overflow
  );

endinterface

// File: rtl/sop_term_match.sv
// Combinational product-term test: a term hits when every variable's
// 2-bit literal accepts that variable's value.
module sop_term_match
  import sop_pkg::*;
#(
  parameter int NVARS = 9
) (
  input  logic [2*NVARS-1:0] term,
  input  logic [NVARS-1:0]   vars,
  output logic               hit
);

  logic [NVARS-1:0] lit_ok;

  generate
    for (genvar gi = 0; gi < NVARS; gi++) begin : g_lit
      assign lit_ok[gi] = sop_lit_ok(term[2*gi +: 2], vars[gi]);
    end
  endgenerate

  assign hit = &lit_ok;

endmodule

// File: rtl/sop_stream_eval.sv
// Sequential SOP evaluator: latch A, OR one product term per cycle, hold Y
// until drained. The top variable is the previous Y when chaining split SOPs.
module sop_stream_eval
  import sop_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int MAX_PRODUCTS = 8
) (
  input logic            clk,
  input logic            rst,
  sop_stream_eval_if.slave bus
);

  localparam int CW = $clog2(MAX_PRODUCTS + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_PRODUCTS);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, a_next;
  logic             partial_reg, partial_next;
  logic             acc_reg, acc_next;
  logic             y_reg, y_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic             ovf_reg, ovf_next;
  logic             term_hit;

  sop_term_match #(
    .NVARS(WIDTH + 1)
  ) u_match (
    .term(bus.t_data),
    .vars({partial_reg, a_reg}),
    .hit (term_hit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      a_reg       <= '0;
      partial_reg <= 1'b0;
      acc_reg     <= 1'b0;
      y_reg       <= 1'b0;
      cnt_reg     <= '0;
      ovf_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      a_reg       <= a_next;
      partial_reg <= partial_next;
      acc_reg     <= acc_next;
      y_reg       <= y_next;
      cnt_reg     <= cnt_next;
      ovf_reg     <= ovf_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    a_next       = a_reg;
    partial_next = partial_reg;
    acc_next     = acc_reg;
    y_next       = y_reg;
    cnt_next     = cnt_reg;
    ovf_next     = ovf_reg;
    case (state_reg)
      IDLE: begin
        if (bus.a_valid) begin
          a_next       = bus.a_data;
          partial_next = bus.chain & y_reg;
          acc_next     = 1'b0;
          cnt_next     = '0;
          state_next   = ACCUM;
        end
      end
      ACCUM: begin
        if (bus.t_valid) begin
          acc_next = acc_reg | term_hit;
          // Counter saturates; the extra term still contributes to Y.
          if (cnt_reg == MAX_CNT) begin
            ovf_next = 1'b1;
          end else begin
            cnt_next = cnt_reg + CW'(1);
          end
          if (bus.t_last) begin
            y_next     = acc_reg | term_hit;
            state_next = HOLD;
          end
        end
      end
      HOLD: begin
        if (bus.y_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs decode registered state only.
  assign bus.a_ready  = (state_reg == IDLE);
  assign bus.t_ready  = (state_reg == ACCUM);
  assign bus.y_valid  = (state_reg == HOLD);
  assign bus.y        = y_reg;
  assign bus.term_cnt = cnt_reg;
  assign bus.overflow = ovf_reg;

endmodule

// File: doc/sop_stream_eval.md
Name: sop_stream_eval

Overview:
- Sequential evaluator for the sum-of-products table encoding produced by the PLA mapping flow: each product term carries 2 bits per variable (bit 2j = complemented literal of A[j], bit 2j+1 = true literal; 00 = don't care, 11 = term constant-false).
- Consumes one product term per cycle, ORs the term results, and returns Y for a latched input vector.
- Variable index WIDTH is the "partial" input: the previous evaluation's Y. This recombines the chained partial/rest SOP pairs that splitting creates when DEPTH exceeds the product limit.
- Used as a bench-side golden model and as an on-chip self-check of mapped GAL_SOP tables.

Parameters:
- WIDTH, 8, number of primary input variables A.
- MAX_PRODUCTS, 8, product terms allowed per evaluation (GAL OLMC product limit).
- CW, $clog2(MAX_PRODUCTS+1), term counter width (derived, not overridable).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- a_valid  in  1  new input vector offered
- a_ready  out  1  block accepts A (IDLE only)
- a_data  in  WIDTH  input vector
- chain  in  1  sampled with A; 1 = keep prior Y as partial variable, 0 = partial variable := 0
- t_valid  in  1  product term offered
- t_ready  out  1  term accepted (ACCUM only)
- t_data  in  2*(WIDTH+1)  one product term, variable WIDTH in bits [2W+1:2W]
- t_last  in  1  final term of this evaluation
- y_valid  out  1  result available
- y_ready  in  1  result consumed
- y  out  1  OR of all accepted term results
- term_cnt  out  CW  terms accepted in current/last evaluation
- overflow  out  1  sticky: more than MAX_PRODUCTS terms seen in one evaluation

Behaviour:
- Reset (synchronous, rst=1 at clk edge): state IDLE; a_ready=1, t_ready=0, y_valid=0, y=0, term_cnt=0, overflow=0, partial register=0, accumulator=0. Reset wins over every other input in the same cycle, including mid-ACCUM and HOLD; a partially consumed term stream is discarded.
- IDLE: a_ready=1. On a_valid: latch a_data; partial := chain ? y_reg : 0; acc := 0; term_cnt := 0 -> ACCUM.
- ACCUM: t_ready=1, a_ready=0. On t_valid:
  - term_hit = AND over j in 0..WIDTH of lit_ok(j), where lit_ok = !(t[2j] & v_j) & !(t[2j+1] & !v_j), v_j = A[j] for j<WIDTH, v_WIDTH = partial.
  - acc := acc | term_hit; term_cnt := term_cnt+1, saturating at MAX_PRODUCTS.
  - If term_cnt already equals MAX_PRODUCTS, set overflow (sticky until reset); the term is still ORed in.
  - If t_last: y := acc | term_hit; -> HOLD.
- HOLD: y_valid=1. On y_ready: y_valid := 0 -> IDLE. y keeps its value (it is the next chain source).
- Latency: Y is valid the cycle after the t_last handshake. Throughput is one term per cycle; A-load and result-drain cost one cycle each.
- Zero-term evaluation is impossible: at least one term (carrying t_last) is required. A term of all zeros is constant-true.
- A term with 11 on any variable never hits.
- No combinational path from t_valid to t_ready or from y_ready to a_ready.

Decomposition:
- Package sop_pkg: the literal encoding constants (LIT_DC=2'b00, LIT_NEG=2'b01, LIT_POS=2'b10, LIT_NONE=2'b11) and the FSM state enum {IDLE, ACCUM, HOLD}.
- One sub-module: sop_term_match (purely combinational, WIDTH+1 variables -> term_hit), shared with the bench reference model.

Test Plan:
- WIDTH=4; A=4'b1010, chain=0; terms {A1&!A0} (t=10'b00_00_00_10_01), last -> y=1 one cycle after the last handshake, term_cnt=1.
- A=4'b0000; terms 10'b00_00_00_00_10, then 10'b00_00_11_00_00 with last -> y=0 (second term constant-false), term_cnt=2.
- Chained split: eval1 with A=4'b0001, term A0 -> y=1. Eval2 with chain=1, same A, term whose only literal is partial (bits[9:8]=10) -> y=1. Repeat with chain=0 -> y=0.
- MAX_PRODUCTS=8; stream 9 non-hitting terms, the 9th hitting -> overflow=1, y=1, term_cnt=8. Overflow stays set after the next clean evaluation.
- Assert rst during ACCUM after 3 terms -> next cycle a_ready=1, y_valid=0, term_cnt=0, overflow=0; a fresh evaluation completes correctly.
- Hold y_ready=0 for 5 cycles in HOLD -> y_valid and y stable, a_ready=0, t_ready=0 throughout.
